score_keeper_team2: RTL and testbench
=====================================

Name: score_keeper_team2

Overview:
- Sequential score/game-state keeper for team 2, directly upstream of the team-2 on-screen score display.
- Converts collision-logic event levels (quaffle goal, snitch catch) into a saturating 14-bit binary score and a playing flag.
- The display stage consumes `score` through its binary-to-BCD converter and `playing_reg` to choose between live digits and the idle pattern.
- Also runs the per-match state machine: idle, playing, finished.

Parameters:
- GOAL_POINTS, 10, points added per quaffle goal.
- SNITCH_POINTS, 150, points added on snitch catch; ends the match.
- SCORE_MAX, 999, saturation ceiling; fits 3 BCD digits and must be ≤ 16383.
- GOAL_HOLDOFF, 25000000, cycles after a counted goal during which further goal edges are ignored (0.5 s at 50 MHz).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start_btn  in  1  asynchronous level from push-button; a rising edge starts or restarts a match.
- goal_hit  in  1  asynchronous level from collision logic; may stay high for many frames.
- snitch_caught  in  1  asynchronous level; team 2 caught the snitch.
- opp_game_over  in  1  synchronous level from the team-1 keeper; opponent caught the snitch.
- score  out  14  current binary score, 0..SCORE_MAX.
- playing_reg  out  1  high while in PLAYING.
- game_over  out  1  high while in FINISHED.
- snitch_ours  out  1  high in FINISHED when team 2 caught the snitch.
- score_pulse  out  1  one-cycle strobe in the cycle `score` changes by a scoring event.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, score=0, holdoff counter=0.
  - playing_reg, game_over, snitch_ours, score_pulse = 0.
  - All synchronizer and edge registers = 0.
  - Deassertion of reset is taken synchronously; first active edge follows.
- Input conditioning:
  - start_btn, goal_hit and snitch_caught each pass through a 2-flop synchronizer plus a delay flop.
  - An edge = sync2 & ~delay, valid for exactly one cycle.
  - Latency: an input high before clk edge k gives an edge term true between edges k+1 and k+2. The resulting register update is visible after edge k+2.
  - opp_game_over is used as a level without synchronization.
- IDLE:
  - score holds its value (0 after reset). playing_reg=0, game_over=0.
  - start edge → PLAYING, score←0, holdoff←0, snitch_ours←0.
- PLAYING (playing_reg=1):
  - Goal counted when goal edge=1 and holdoff=0: score←min(score+GOAL_POINTS, SCORE_MAX), holdoff←GOAL_HOLDOFF-1, score_pulse=1.
  - Goal edge while holdoff≠0 is dropped, not queued.
  - Holdoff decrements by 1 each cycle while nonzero.
  - Snitch edge: score←min(score+SNITCH_POINTS, SCORE_MAX), snitch_ours←1, score_pulse=1, → FINISHED.
  - Goal and snitch edges in the same cycle (holdoff=0): add both as one sum, min(score+GOAL_POINTS+SNITCH_POINTS, SCORE_MAX), single score_pulse, → FINISHED.
  - opp_game_over=1 with no snitch edge → FINISHED, score unchanged, snitch_ours=0.
  - opp_game_over=1 and snitch edge in the same cycle: the snitch wins (snitch_ours=1, points added).
  - Start edge while PLAYING: restart, score←0, holdoff←0, stay PLAYING. Start has priority over goal and snitch in that cycle.
  - Saturation: a counted event when score is already at SCORE_MAX still pulses score_pulse, but score stays at SCORE_MAX.
  - The sum is computed at 15 bits before clamping, so there is no wrap-around.
- FINISHED (game_over=1):
  - score frozen; goal and snitch edges ignored; holdoff cleared.
  - Start edge → PLAYING with score←0, snitch_ours←0.
- Outputs:
  - All outputs are registered.
  - playing_reg and game_over are decoded from the state register; they are never both 1.
- Reset mid-match returns to IDLE with score=0 regardless of state or holdoff.

Test Plan:
1. (GOAL_HOLDOFF=8 for all tests) Reset low 3 cycles → all outputs 0. Release, pulse start 1 cycle → playing_reg=1 after the 3rd edge, score=0.
2. PLAYING, goal_hit held high 20 cycles → score=10 after edge k+2 with score_pulse for 1 cycle. No further increment, since the level stays high without a new edge.
3. Two goal rising edges 4 cycles apart → score=10 only (second dropped by holdoff). A third edge 10 cycles after the first → score=20.
4. Score preloaded to 990 via 99 goals → snitch edge gives score=999 (saturated), game_over=1, snitch_ours=1, playing_reg=0. A subsequent goal edge leaves 999.
5. Goal and snitch rising in the same cycle from score=40 → score=200, single score_pulse, FINISHED. In a separate run, opp_game_over from score=30 → FINISHED, score=30, snitch_ours=0.
6. Reset asserted mid-holdoff with score=70 → immediate score=0, IDLE. Start after release → PLAYING, and a goal edge 1 cycle later counts (holdoff cleared) → score=10.

Source files
------------

// File: rtl/score_keeper_team2.sv
// -----------------------------------------------------------------------------
// score_keeper_team2
//   Score and match-state keeper for team 2. Event levels from the collision
//   logic are turned into one-cycle edges. These edges drive a saturating binary
//   score and a three-state match FSM (idle / playing / finished). The score
//   display stage downstream reads o_score and o_playing_reg.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start_btn      async level, rising edge starts/restarts a match
//   i_goal_hit       async level, rising edge is a quaffle goal
//   i_snitch_caught  async level, rising edge is a team-2 snitch catch
//   i_opp_game_over  synchronous level from team-1 keeper (opponent snitch)
//   o_score          binary score, 0..SCORE_MAX
//   o_playing_reg    high while a match is in progress
//   o_game_over      high once the match has finished
//   o_snitch_ours    high in finished state when team 2 caught the snitch
//   o_score_pulse    one-cycle strobe coinciding with a scoring update
// -----------------------------------------------------------------------------
module score_keeper_team2 #(
    parameter int unsigned GOAL_POINTS   = 10,
    parameter int unsigned SNITCH_POINTS = 150,
    parameter int unsigned SCORE_MAX     = 999,
    // Must be at least 1; the counter reloads with GOAL_HOLDOFF-1.
    parameter int unsigned GOAL_HOLDOFF  = 25000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_btn,
    input  logic        i_goal_hit,
    input  logic        i_snitch_caught,
    input  logic        i_opp_game_over,
    output logic [13:0] o_score,
    output logic        o_playing_reg,
    output logic        o_game_over,
    output logic        o_snitch_ours,
    output logic        o_score_pulse
);

    localparam int unsigned HOLD_W = (GOAL_HOLDOFF > 1) ? $clog2(GOAL_HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GOAL_HOLDOFF - 1);

    // Arithmetic is carried at 15 bits so the clamp sees the true sum.
    localparam logic [14:0] ADD_GOAL   = 15'(GOAL_POINTS);
    localparam logic [14:0] ADD_SNITCH = 15'(SNITCH_POINTS);
    localparam logic [14:0] ADD_BOTH   = 15'(GOAL_POINTS + SNITCH_POINTS);
    localparam logic [14:0] MAX_15     = 15'(SCORE_MAX);

    // Bit positions inside the conditioning vectors.
    localparam int unsigned IDX_START  = 0;
    localparam int unsigned IDX_GOAL   = 1;
    localparam int unsigned IDX_SNITCH = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPlaying  = 2'd1,
        StFinished = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchronizer plus delay flop per input
    // ------------------------------------------------------------------
    logic [2:0] w_async_in;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_dly;
    logic [2:0] w_edge;

    assign w_async_in = {i_snitch_caught, i_goal_hit, i_start_btn};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_dly   <= '0;
        end else begin
            r_sync1 <= w_async_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_dly;

    logic w_start_edge;
    logic w_goal_edge;
    logic w_snitch_edge;

    assign w_start_edge  = w_edge[IDX_START];
    assign w_goal_edge   = w_edge[IDX_GOAL];
    assign w_snitch_edge = w_edge[IDX_SNITCH];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_e            r_state;
    state_e            w_state_nxt;
    logic [13:0]       r_score;
    logic [13:0]       w_score_nxt;
    logic [HOLD_W-1:0] r_holdoff;
    logic [HOLD_W-1:0] w_holdoff_nxt;
    logic              r_snitch_ours;
    logic              w_snitch_ours_nxt;
    logic              r_score_pulse;
    logic              w_score_pulse_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_score       <= '0;
            r_holdoff     <= '0;
            r_snitch_ours <= 1'b0;
            r_score_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_score       <= w_score_nxt;
            r_holdoff     <= w_holdoff_nxt;
            r_snitch_ours <= w_snitch_ours_nxt;
            r_score_pulse <= w_score_pulse_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scoring arithmetic
    // ------------------------------------------------------------------
    logic        w_goal_ok;
    logic [14:0] w_add;
    logic [14:0] w_sum;
    logic [13:0] w_sat;

    // A goal edge only counts once the holdoff window has drained.
    assign w_goal_ok = w_goal_edge && (r_holdoff == '0);

    always_comb begin
        w_add = '0;
        if (w_snitch_edge) begin
            w_add = w_goal_ok ? ADD_BOTH : ADD_SNITCH;
        end else if (w_goal_ok) begin
            w_add = ADD_GOAL;
        end
    end

    assign w_sum = {1'b0, r_score} + w_add;
    assign w_sat = (w_sum > MAX_15) ? MAX_15[13:0] : w_sum[13:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_score_nxt       = r_score;
        w_holdoff_nxt     = (r_holdoff != '0) ? (r_holdoff - 1'b1) : '0;
        w_snitch_ours_nxt = r_snitch_ours;
        w_score_pulse_nxt = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_start_edge) begin
                    w_state_nxt       = StPlaying;
                    w_score_nxt       = '0;
                    w_holdoff_nxt     = '0;
                    w_snitch_ours_nxt = 1'b0;
                end
            end

            StPlaying: begin
                if (w_start_edge) begin
                    // Restart beats any scoring edge arriving in the same cycle.
                    w_score_nxt       = '0;
                    w_holdoff_nxt     = '0;
                    w_snitch_ours_nxt = 1'b0;
                end else if (w_snitch_edge) begin
                    // Our snitch wins over a simultaneous opponent game-over.
                    w_state_nxt       = StFinished;
                    w_score_nxt       = w_sat;
                    w_snitch_ours_nxt = 1'b1;
                    w_score_pulse_nxt = 1'b1;
                end else if (i_opp_game_over) begin
                    w_state_nxt       = StFinished;
                    w_snitch_ours_nxt = 1'b0;
                end else if (w_goal_ok) begin
                    w_score_nxt       = w_sat;
                    w_holdoff_nxt     = HOLD_LOAD;
                    w_score_pulse_nxt = 1'b1;
                end
            end

            StFinished: begin
                w_holdoff_nxt = '0;
                if (w_start_edge) begin
                    w_state_nxt       = StPlaying;
                    w_score_nxt       = '0;
                    w_snitch_ours_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt   = StIdle;
                w_score_nxt   = '0;
                w_holdoff_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, all taken straight from registers
    // ------------------------------------------------------------------
    assign o_score       = r_score;
    assign o_playing_reg = (r_state == StPlaying);
    assign o_game_over   = (r_state == StFinished);
    assign o_snitch_ours = r_snitch_ours;
    assign o_score_pulse = r_score_pulse;

endmodule

// File: tb/tb_score_keeper_team2.sv
`timescale 1ns/1ps
module tb_score_keeper_team2;

    localparam int GP   = 10;
    localparam int SP   = 150;
    localparam int SMAX = 999;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        goal = 1'b0;
    logic        snitch = 1'b0;
    logic        opp = 1'b0;
    logic [13:0] score;
    logic        playing;
    logic        game_over;
    logic        snitch_ours;
    logic        pulse;

    score_keeper_team2 #(
        .GOAL_POINTS  (GP),
        .SNITCH_POINTS(SP),
        .SCORE_MAX    (SMAX),
        .GOAL_HOLDOFF (HOLD)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start_btn    (start),
        .i_goal_hit     (goal),
        .i_snitch_caught(snitch),
        .i_opp_game_over(opp),
        .o_score        (score),
        .o_playing_reg  (playing),
        .o_game_over    (game_over),
        .o_snitch_ours  (snitch_ours),
        .o_score_pulse  (pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int score;
        bit go;
        bit so;
    } exp_t;

    exp_t sb_q[$];

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_FIN  = 2;

    int     m_state = M_IDLE;
    int     m_score = 0;
    bit     m_so    = 1'b0;
    bit     m_armed = 1'b0;   // a goal has been counted in this match
    longint m_last  = 0;      // cycle of the last counted goal
    longint m_cyc   = 0;
    // Input samples from the previous three clock edges ([0] = newest).
    bit     hs[3];
    bit     hg[3];
    bit     hn[3];

    function automatic int clamp(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_score = 0;
        m_so    = 1'b0;
        m_armed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hs[i] = 1'b0;
            hg[i] = 1'b0;
            hn[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    task automatic model_step();
        bit   rs;
        bit   rg;
        bit   rn;
        bit   g_ok;
        bit   pz;
        exp_t e;
        // A rising level sampled two edges ago takes effect on this edge.
        rs   = hs[1] & ~hs[2];
        rg   = hg[1] & ~hg[2];
        rn   = hn[1] & ~hn[2];
        g_ok = rg && (!m_armed || (m_cyc - m_last >= HOLD));
        pz   = 1'b0;
        case (m_state)
            M_IDLE: begin
                if (rs) begin
                    m_state = M_PLAY; m_score = 0; m_so = 1'b0; m_armed = 1'b0;
                end
            end
            M_PLAY: begin
                if (rs) begin
                    m_score = 0; m_so = 1'b0; m_armed = 1'b0;
                end else if (rn) begin
                    m_score = clamp(m_score + SP + (g_ok ? GP : 0));
                    m_so = 1'b1; m_state = M_FIN; m_armed = 1'b0; pz = 1'b1;
                end else if (opp) begin
                    m_state = M_FIN; m_so = 1'b0; m_armed = 1'b0;
                end else if (g_ok) begin
                    m_score = clamp(m_score + GP); m_armed = 1'b1; m_last = m_cyc; pz = 1'b1;
                end
            end
            default: begin
                if (rs) begin
                    m_state = M_PLAY; m_score = 0; m_so = 1'b0; m_armed = 1'b0;
                end
            end
        endcase
        if (pz) begin
            e.score = m_score;
            e.go    = (m_state == M_FIN);
            e.so    = m_so;
            sb_q.push_back(e);
        end
        hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start;
        hg[2] = hg[1]; hg[1] = hg[0]; hg[0] = goal;
        hn[2] = hn[1]; hn[1] = hn[0]; hn[0] = snitch;
        m_cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pulse) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_spurious: score_pulse=1 score=%0d, no update expected",
                             score);
                end else begin
                    e = sb_q.pop_front();
                    if (score != 14'(e.score) || game_over != e.go || snitch_ours != e.so) begin
                        errors++;
                        $display("FAIL pulse_value: got score=%0d go=%0b so=%0b expected %0d %0b %0b",
                                 score, game_over, snitch_ours, e.score, e.go, e.so);
                    end
                end
            end else if (sb_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL pulse_missing: score_pulse=0 expected pulse with score=%0d",
                         sb_q[0].score);
                sb_q.delete();
            end
            checks++;
            if (score != 14'(m_score) || playing != (m_state == M_PLAY) ||
                game_over != (m_state == M_FIN) || snitch_ours != m_so) begin
                errors++;
                $display("FAIL state @%0t: got score=%0d pl=%0b go=%0b so=%0b expected %0d %0b %0b %0b",
                         $time, score, playing, game_over, snitch_ours, m_score,
                         m_state == M_PLAY, m_state == M_FIN, m_so);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart();
        start = 1'b1; tick(1); start = 1'b0; tick(3);
    endtask

    task automatic goal_pulse();
        goal = 1'b1; tick(1); goal = 1'b0; tick(9);
    endtask

    task automatic do_reset(input int n);
        #2 rst_n = 1'b0;
        tick(n);
        #2 rst_n = 1'b1;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int np;
        // 1: reset state and start latency
        tick(3);
        chk("rst_score", int'(score), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_snitch_ours", int'(snitch_ours), 0);
        chk("rst_pulse", int'(pulse), 0);
        rst_n = 1'b1;
        tick(1);
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        chk("t1_playing_early", int'(playing), 0);
        tick(1);
        chk("t1_playing", int'(playing), 1);
        chk("t1_score", int'(score), 0);

        // 2: held goal level counts once
        goal = 1'b1;
        tick(2);
        chk("t2_score_early", int'(score), 0);
        tick(1);
        chk("t2_score", int'(score), 10);
        chk("t2_pulse", int'(pulse), 1);
        tick(1);
        chk("t2_pulse_once", int'(pulse), 0);
        tick(16);
        chk("t2_held", int'(score), 10);
        goal = 1'b0;
        tick(10);

        // 3: holdoff drops a close second goal
        restart();
        goal = 1'b1; tick(1); goal = 1'b0; tick(3);
        goal = 1'b1; tick(1); goal = 1'b0; tick(5);
        goal = 1'b1; tick(1); goal = 1'b0; tick(1);
        chk("t3_dropped", int'(score), 10);
        tick(1);
        chk("t3_third", int'(score), 20);

        // 4: saturation on snitch
        restart();
        repeat (99) goal_pulse();
        chk("t4_preload", int'(score), 990);
        snitch = 1'b1; tick(1); snitch = 1'b0; tick(3);
        chk("t4_sat", int'(score), 999);
        chk("t4_game_over", int'(game_over), 1);
        chk("t4_snitch_ours", int'(snitch_ours), 1);
        chk("t4_playing", int'(playing), 0);
        goal_pulse();
        chk("t4_frozen", int'(score), 999);

        // 5a: goal and snitch together
        restart();
        repeat (4) goal_pulse();
        chk("t5_preload", int'(score), 40);
        goal = 1'b1; snitch = 1'b1; tick(1); goal = 1'b0; snitch = 1'b0;
        np = 0;
        repeat (6) begin
            tick(1);
            np += int'(pulse);
        end
        chk("t5_pulses", np, 1);
        chk("t5_score", int'(score), 200);
        chk("t5_game_over", int'(game_over), 1);
        // 5b: opponent ends the match
        restart();
        repeat (3) goal_pulse();
        opp = 1'b1; tick(1); opp = 1'b0;
        chk("t5_opp_game_over", int'(game_over), 1);
        chk("t5_opp_score", int'(score), 30);
        chk("t5_opp_snitch", int'(snitch_ours), 0);
        chk("t5_opp_playing", int'(playing), 0);

        // 6: reset mid-holdoff
        restart();
        repeat (6) goal_pulse();
        goal = 1'b1; tick(1); goal = 1'b0; tick(3);
        chk("t6_preload", int'(score), 70);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_score", int'(score), 0);
        chk("t6_rst_playing", int'(playing), 0);
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);
        start = 1'b1; tick(1); start = 1'b0;
        goal = 1'b1; tick(1); goal = 1'b0;
        tick(1);
        chk("t6_playing", int'(playing), 1);
        tick(1);
        chk("t6_goal", int'(score), 10);
        tick(10);

        // random phase against the model
        repeat (4000) begin
            start  = ($urandom_range(0, 49) == 0);
            goal   = 1'($urandom_range(0, 1));
            snitch = ($urandom_range(0, 59) == 0);
            opp    = ($urandom_range(0, 89) == 0);
            if ($urandom_range(0, 799) == 0) do_reset(2);
            else tick(1);
        end
        start = 1'b0; goal = 1'b0; snitch = 1'b0; opp = 1'b0;
        tick(5);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
